// File: rtl/microaddr_return_stack_pkg.sv
// Control-unit shared definitions: microaddress width/type and return-stack depth.
package microaddr_return_stack_pkg;

    localparam int UADDR_W  = 8;
    localparam int RS_DEPTH = 4;

    typedef logic [UADDR_W-1:0] uaddr_t;

endpackage

// File: rtl/microaddr_return_stack.sv
// LIFO of microsubroutine return addresses; top-of-stack is presented
// combinationally from registers so a return resolves in the selecting cycle.
module microaddr_return_stack
    import microaddr_return_stack_pkg::*;
#(
    parameter int AW    = UADDR_W,
    parameter int DEPTH = RS_DEPTH
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic [AW-1:0] IncAddr,
    input  logic          Push,
    input  logic          Pop,
    input  logic          ClrErr,
    output logic [AW-1:0] RetAddr,
    output logic          Empty,
    output logic          Full,
    output logic          Overflow,
    output logic          Underflow
);

    localparam int SPW = $clog2(DEPTH + 1);

    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_nxt;
    logic [AW-1:0]  entries [DEPTH];
    logic [DEPTH-1:0] we;
    logic [SPW-1:0] wr_idx;
    logic           wr_en;
    logic           set_ovf;
    logic           set_unf;
    logic [AW-1:0]  top;

    assign Empty = (sp == '0);
    assign Full  = (sp == SPW'(DEPTH));

    always_comb begin
        sp_nxt  = sp;
        wr_en   = 1'b0;
        wr_idx  = sp;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (Push && Pop) begin
            if (Empty) begin
                // return on an empty stack still lets the call land in slot 0
                wr_en   = 1'b1;
                wr_idx  = '0;
                sp_nxt  = SPW'(1);
                set_unf = 1'b1;
            end else begin
                wr_en  = 1'b1;
                wr_idx = sp - SPW'(1);
            end
        end else if (Push) begin
            if (Full) begin
                set_ovf = 1'b1;
            end else begin
                wr_en  = 1'b1;
                wr_idx = sp;
                sp_nxt = sp + SPW'(1);
            end
        end else if (Pop) begin
            if (Empty) begin
                set_unf = 1'b1;
            end else begin
                sp_nxt = sp - SPW'(1);
            end
        end
    end

    always_comb begin
        we  = '0;
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            we[i] = wr_en && (wr_idx == SPW'(i));
            if (sp == SPW'(i + 1)) top = entries[i];
        end
    end

    assign RetAddr = top;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sp        <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            sp        <= sp_nxt;
            // a same-cycle error takes priority over the clear
            Overflow  <= (Overflow  && !ClrErr) || set_ovf;
            Underflow <= (Underflow && !ClrErr) || set_unf;
            for (int i = 0; i < DEPTH; i++) begin
                if (we[i]) entries[i] <= IncAddr;
            end
        end
    end

endmodule

// File: tb/tb_microaddr_return_stack.sv
// Scoreboard bench for microaddr_return_stack with DEPTH=4, AW=8.
module tb_microaddr_return_stack;

    typedef struct packed {
        logic [7:0] ret;
        logic       emp;
        logic       full;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] IncAddr = '0;
    logic       Push = 1'b0;
    logic       Pop = 1'b0;
    logic       ClrErr = 1'b0;
    logic [7:0] RetAddr;
    logic       Empty;
    logic       Full;
    logic       Overflow;
    logic       Underflow;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [7:0] last_ret = '0;

    microaddr_return_stack #(.AW(8), .DEPTH(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IncAddr(IncAddr), .Push(Push), .Pop(Pop),
        .ClrErr(ClrErr), .RetAddr(RetAddr), .Empty(Empty), .Full(Full),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_ret"},   32'(RetAddr),   32'(e.ret));
        chk({tag, "_empty"}, 32'(Empty),     32'(e.emp));
        chk({tag, "_full"},  32'(Full),      32'(e.full));
        chk({tag, "_ovf"},   32'(Overflow),  32'(e.ovf));
        chk({tag, "_unf"},   32'(Underflow), 32'(e.unf));
    endtask

    // Drive one cycle of stimulus, queue the post-edge expectation, then check it.
    task automatic step(input string tag, input logic push_i, input logic pop_i,
                        input logic clr_i, input logic [7:0] inc,
                        input logic [7:0] e_ret, input logic e_emp, input logic e_full,
                        input logic e_ovf, input logic e_unf);
        chk({tag, "_pre"}, 32'(RetAddr), 32'(last_ret));
        Push = push_i;
        Pop = pop_i;
        ClrErr = clr_i;
        IncAddr = inc;
        sb.push_back('{ret: e_ret, emp: e_emp, full: e_full, ovf: e_ovf, unf: e_unf});
        last_ret = e_ret;
        @(posedge CLK);
        #1;
        Push = 1'b0;
        Pop = 1'b0;
        ClrErr = 1'b0;
        compare(tag);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        sb.push_back('{ret: 8'h00, emp: 1'b1, full: 1'b0, ovf: 1'b0, unf: 1'b0});
        compare("rst");
        RESET_N = 1'b1;

        for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, 8'hAB, 8'h00, 1, 0, 0, 0);

        step("push11", 1, 0, 0, 8'h11, 8'h11, 0, 0, 0, 0);
        step("push22", 1, 0, 0, 8'h22, 8'h22, 0, 0, 0, 0);
        step("push33", 1, 0, 0, 8'h33, 8'h33, 0, 0, 0, 0);
        step("push44", 1, 0, 0, 8'h44, 8'h44, 0, 1, 0, 0);
        step("ovf55",  1, 0, 0, 8'h55, 8'h44, 0, 1, 1, 0);
        step("hold",   0, 0, 0, 8'h66, 8'h44, 0, 1, 1, 0);
        step("clrovf", 0, 0, 1, 8'h00, 8'h44, 0, 1, 0, 0);
        step("pop1",   0, 1, 0, 8'h00, 8'h33, 0, 0, 0, 0);
        step("pop2",   0, 1, 0, 8'h00, 8'h22, 0, 0, 0, 0);
        step("pop3",   0, 1, 0, 8'h00, 8'h11, 0, 0, 0, 0);
        step("pop4",   0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0);

        step("p11",    1, 0, 0, 8'h11, 8'h11, 0, 0, 0, 0);
        step("p22",    1, 0, 0, 8'h22, 8'h22, 0, 0, 0, 0);
        step("repl99", 1, 1, 0, 8'h99, 8'h99, 0, 0, 0, 0);
        step("popr",   0, 1, 0, 8'h00, 8'h11, 0, 0, 0, 0);
        step("popr2",  0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0);

        step("unf",    0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 1);
        step("clrunf", 0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0);
        step("pp7a",   1, 1, 0, 8'h7A, 8'h7A, 0, 0, 0, 1);
        step("pop7a",  0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 1);
        step("setwin", 1, 1, 1, 8'h12, 8'h12, 0, 0, 0, 1);

        step("f21",    1, 0, 1, 8'h21, 8'h21, 0, 0, 0, 0);
        step("f31",    1, 0, 0, 8'h31, 8'h31, 0, 0, 0, 0);
        step("f41",    1, 0, 0, 8'h41, 8'h41, 0, 1, 0, 0);
        step("full_pp",1, 1, 0, 8'h5A, 8'h5A, 0, 1, 0, 0);
        step("fpop1",  0, 1, 0, 8'h00, 8'h31, 0, 0, 0, 0);
        step("fpop2",  0, 1, 0, 8'h00, 8'h21, 0, 0, 0, 0);

        // mid-cycle asynchronous reset with two entries held
        #2;
        RESET_N = 1'b0;
        #1;
        sb.push_back('{ret: 8'h00, emp: 1'b1, full: 1'b0, ovf: 1'b0, unf: 1'b0});
        compare("arst");
        @(posedge CLK);
        #1;
        sb.push_back('{ret: 8'h00, emp: 1'b1, full: 1'b0, ovf: 1'b0, unf: 1'b0});
        compare("arst_hold");
        RESET_N = 1'b1;
        last_ret = 8'h00;
        step("post_rst", 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        step("post_pop", 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/microaddr_return_stack.md
# microaddr_return_stack

Hardware LIFO of microprogram return addresses for the control-unit sequencer. It is the consumer of the incrementer register's 8-bit output. On a microsubroutine call it captures the already-incremented microaddress. On a return it supplies that address back to the next-address multiplexer. Top-of-stack is always presented combinationally from registers, so a return resolves in the cycle the sequencer selects it.

## Interface
- AW, 8, microaddress width; must match the incrementer register width.
- DEPTH, 4, number of stack entries; legal range 2..16.
- CLK  in  1  rising-edge clock shared with the control unit.
- RESET_N  in  1  asynchronous, active-low reset.
- IncAddr  in  AW  incremented microaddress (incrementer register Q).
- Push  in  1  microcall: store IncAddr on stack.
- Pop  in  1  microreturn: discard top entry.
- ClrErr  in  1  synchronous clear of sticky error flags.
- RetAddr  out  AW  current top-of-stack; 0 when empty.
- Empty  out  1  no valid entries.
- Full  out  1  DEPTH valid entries.
- Overflow  out  1  sticky: a Push was dropped because the stack was full.
- Underflow  out  1  sticky: a Pop occurred while the stack was empty.

## Operation
- State:
  - stack pointer `sp`, width clog2(DEPTH+1), counting valid entries 0..DEPTH;
  - DEPTH×AW entry array;
  - two sticky flags.
- Reset (RESET_N low, any time, including mid-operation):
  - sp=0, all entries=0, Overflow=Underflow=0;
  - outputs become RetAddr=0, Empty=1, Full=0;
  - state is held while RESET_N stays low.
- Push only:
  - not full: entry[sp] <= IncAddr, sp <= sp+1;
  - full: no change to entries or sp; Overflow <= 1.
- Pop only:
  - not empty: sp <= sp-1; entry contents are left as-is;
  - empty: no change; Underflow <= 1.
- Push and Pop together (return immediately followed by a call):
  - not empty: entry[sp-1] <= IncAddr, sp unchanged (replace top). This applies even when full and does not set Overflow.
  - empty: behaves as Push only (sp becomes 1, entry[0]=IncAddr) and Underflow <= 1.
- Neither asserted: hold.
- ClrErr:
  - clears both sticky flags at the clock edge;
  - if the same cycle also raises an error, the set wins.
- Outputs:
  - RetAddr = entry[sp-1] when sp≠0, otherwise 0;
  - Empty = (sp==0);
  - Full = (sp==DEPTH).
- No wrap-around: the pointer saturates at 0 and at DEPTH and never aliases.

## Timing
- All state updates occur on the rising edge of CLK. Reset is the only asynchronous path.
- RetAddr, Empty and Full are combinational from registered state only; there is no input-to-output combinational path.
- Push latency: the pushed value appears on RetAddr in the cycle after the edge.
- Pop latency: the next-lower entry (or 0) appears on RetAddr in the cycle after the edge.
- The sequencer samples RetAddr in the same cycle it asserts Pop; the value it sees is the pre-pop top.
- Flags update on the same edge as the offending request and are visible the next cycle.

## Structure
- Shared control-unit package holds:
  - the microaddress width constant (8);
  - the microaddress typedef, shared with the incrementer register;
  - the default return-stack depth constant.
- Single flat module: the pointer, array and flags are simple enough that no sub-module is warranted.
- Entry storage is a plain register array with per-entry write enables; no RAM macro is inferred.

## Test plan
- Reset then idle: RetAddr=0x00, Empty=1, Full=0, both flags 0 on every cycle.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles (DEPTH=4):
  - Full=1 after the fourth push;
  - Pop ×4 yields RetAddr 0x44, 0x33, 0x22, 0x11, then 0x00 with Empty=1.
- Full stack, Push 0x55: contents unchanged, RetAddr=0x44, Overflow=1. ClrErr then clears Overflow.
- Stack holding 0x11 and 0x22, Push and Pop together with IncAddr=0x99:
  - sp stays 2, RetAddr=0x99;
  - subsequent Pop gives 0x11.
- Empty stack:
  - Pop sets Underflow=1, sp stays 0;
  - Push and Pop together with 0x7A leaves sp=1, RetAddr=0x7A, Underflow=1.
- Two entries pushed, RESET_N pulsed low mid-cycle: outputs go to reset values immediately (asynchronously), without waiting for a clock edge.
